// File: rtl/s38417_pkg.sv
// Shared types and helpers for the s38417 phase-select driver.
// Both the top and the word bank import this package.
package s38417_pkg;

    typedef logic [2:0] phase_sel_t;

    localparam phase_sel_t SEL_NONE = 3'b000;
    localparam phase_sel_t SEL_P0   = 3'b001;
    localparam phase_sel_t SEL_P1   = 3'b010;
    localparam phase_sel_t SEL_P2   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } phase_state_e;

    function automatic phase_sel_t phase_to_sel(input logic [1:0] ph);
        phase_sel_t s;
        case (ph)
            2'd0:    s = SEL_P0;
            2'd1:    s = SEL_P1;
            2'd2:    s = SEL_P2;
            default: s = SEL_NONE;
        endcase
        return s;
    endfunction

    // Picks the bit of a code word that is driven during phase ph.
    function automatic logic word_bit(input logic [2:0] w, input logic [1:0] ph);
        logic b;
        case (ph)
            2'd0:    b = w[0];
            2'd1:    b = w[1];
            2'd2:    b = w[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/s38417_word_bank.sv
// Bank of NWORDS 3-bit code words with range-checked writes and a sticky error flag.
// The read port forwards a same-cycle write so a frame started together with a write sees it.
module s38417_word_bank
    import s38417_pkg::*;
#(
    parameter int NWORDS = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        addr,
    input  logic [2:0]        wdata,
    input  logic              wr_open,
    input  logic [1:0]        rd_phase,
    output logic [NWORDS-1:0] rd_bits,
    output logic              err
);

    logic [2:0] bank_r [NWORDS];
    logic       err_r;
    logic       addr_ok_s;
    logic       wr_ok_s;

    assign addr_ok_s = ({1'b0, addr} < 5'(NWORDS));
    assign wr_ok_s   = we & wr_open & addr_ok_s;
    assign err       = err_r;

    // Word storage and sticky error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                bank_r[i] <= 3'b000;
            end
            err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                if (wr_ok_s && (addr == 4'(i))) begin
                    bank_r[i] <= wdata;
                end
            end
            if (we && !(wr_open && addr_ok_s)) begin
                err_r <= 1'b1;
            end
        end
    end

    // Phase slice of every word, with write forwarding.
    always_comb begin
        rd_bits = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (wr_ok_s && (addr == 4'(i))) begin
                rd_bits[i] = word_bit(wdata, rd_phase);
            end else begin
                rd_bits[i] = word_bit(bank_r[i], rd_phase);
            end
        end
    end

endmodule

// File: rtl/s38417_phase_sel_gen.sv
// Drives the 3-phase one-hot select bus and per-phase word bits for the s38417 compare cone.
// A frame walks phases 0..2, each held HOLD_CYC cycles with GAP_CYC idle cycles in between.
module s38417_phase_sel_gen
    import s38417_pkg::*;
#(
    parameter int NWORDS   = 15,
    parameter int HOLD_CYC = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [2:0]        cfg_wdata,
    output logic              busy,
    output phase_sel_t        sel,
    output logic [NWORDS-1:0] word_bits,
    output logic              frame_valid,
    output logic              done,
    output logic              cfg_err
);

    if (NWORDS < 1 || NWORDS > 16) begin : g_bad_nwords
        $error("NWORDS must be in 1..16");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("HOLD_CYC must be in 1..15");
    end
    if (GAP_CYC < 0 || GAP_CYC > 15) begin : g_bad_gap
        $error("GAP_CYC must be in 0..15");
    end

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
    localparam bit         HAS_GAP   = (GAP_CYC > 0);

    phase_state_e      state_r;
    logic [1:0]        phase_r;
    logic [3:0]        cnt_r;
    logic              busy_r;
    phase_sel_t        sel_r;
    logic [NWORDS-1:0] word_bits_r;
    logic              frame_valid_r;
    logic              done_r;

    logic              pres_s;
    logic [1:0]        pres_phase_s;
    logic [NWORDS-1:0] rd_bits_s;
    logic              hold_end_s;
    logic              gap_end_s;

    assign hold_end_s = (cnt_r == HOLD_LAST);
    assign gap_end_s  = (cnt_r == GAP_LAST);

    s38417_word_bank #(
        .NWORDS (NWORDS)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cfg_we),
        .addr     (cfg_addr),
        .wdata    (cfg_wdata),
        .wr_open  (state_r == ST_IDLE),
        .rd_phase (pres_phase_s),
        .rd_bits  (rd_bits_s),
        .err      (cfg_err)
    );

    // Which phase, if any, is presented in the next cycle; feeds the registered outputs.
    always_comb begin
        pres_s       = 1'b0;
        pres_phase_s = phase_r;
        case (state_r)
            ST_IDLE: begin
                pres_s       = start;
                pres_phase_s = 2'd0;
            end
            ST_PHASE: begin
                if (!hold_end_s) begin
                    pres_s = 1'b1;
                end else if ((phase_r != 2'd2) && !HAS_GAP) begin
                    pres_s       = 1'b1;
                    pres_phase_s = phase_r + 2'd1;
                end else begin
                    pres_s = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    pres_s       = 1'b1;
                    pres_phase_s = phase_r + 2'd1;
                end else begin
                    pres_s = 1'b0;
                end
            end
            ST_DONE: pres_s = 1'b0;
            default: pres_s = 1'b0;
        endcase
    end

    // Frame FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            phase_r       <= 2'd0;
            cnt_r         <= 4'd0;
            busy_r        <= 1'b0;
            sel_r         <= SEL_NONE;
            word_bits_r   <= '0;
            frame_valid_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            sel_r         <= pres_s ? phase_to_sel(pres_phase_s) : SEL_NONE;
            frame_valid_r <= pres_s;
            word_bits_r   <= pres_s ? rd_bits_s : '0;
            done_r        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_PHASE;
                        phase_r <= 2'd0;
                        cnt_r   <= 4'd0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_PHASE: begin
                    if (hold_end_s) begin
                        cnt_r <= 4'd0;
                        if (phase_r == 2'd2) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (HAS_GAP) begin
                            state_r <= ST_GAP;
                        end else begin
                            phase_r <= phase_r + 2'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        state_r <= ST_PHASE;
                        phase_r <= phase_r + 2'd1;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign sel         = sel_r;
    assign word_bits   = word_bits_r;
    assign frame_valid = frame_valid_r;
    assign done        = done_r;

    a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel_r));

endmodule
